block_swap_reg_file: RTL

//  Register file (DEPTH = 2**ADDR_WIDTH words) with an internal block-move engine.
//  The engine performs multi-word SWAP or COPY between two address ranges under a start/busy/done handshake.
//  It generalises the single-word swap register file to run-length blocks, a copy mode, and overlap handling.
//  It sits between a host port (normal read/write) and the memory-swapper control logic.

---
 rtl/block_swap_reg_file.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/block_swap_reg_file.sv
// ============================================================================
// Module  : block_swap_reg_file
// Purpose : Register file with a block-move engine that swaps or copies ranges.
// Revision: 1.0
// ============================================================================
`default_nettype none

module block_swap_reg_file #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] address_w,
   input  logic [DATA_WIDTH-1:0] data_w,
   input  logic [ADDR_WIDTH-1:0] address_r,
   output logic [DATA_WIDTH-1:0] data_r,
   input  logic                  start,
   input  logic                  op,
   input  logic [ADDR_WIDTH-1:0] address_A,
   input  logic [ADDR_WIDTH-1:0] address_B,
   input  logic [ADDR_WIDTH-1:0] len,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int IW    = ADDR_WIDTH + 1;
   localparam logic [IW-1:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [IW-1:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_MOVE  = 3'd2,
      S_STORE = 3'd3,
      S_COPY  = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   a_q, b_q, len_q;
   logic [IW-1:0]           idx_q;
   logic                    desc_q;
   logic [DATA_WIDTH-1:0]   tmp_q;
   logic                    busy_q, done_q, err_q;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic [IW-1:0]           off_w;
   logic [ADDR_WIDTH-1:0]   addr_a_w, addr_b_w;
   logic                    last_w;
   logic [ADDR_WIDTH-1:0]   d_w;
   logic [IW-1:0]           d_ext_w, len_ext_w;
   logic                    null_w, ovl_w, desc_w;
   logic                    mem_we_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_d;
   logic [DATA_WIDTH-1:0]   mem_data_d;

   assign data_r = mem_q[address_r];
   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;

   // Descending copies walk from the top of the block down.
   assign off_w    = desc_q ? ({1'b0, len_q} - idx_q - ONE_C) : idx_q;
   assign addr_a_w = a_q + off_w[ADDR_WIDTH-1:0];
   assign addr_b_w = b_q + off_w[ADDR_WIDTH-1:0];
   assign last_w   = ((idx_q + ONE_C) == {1'b0, len_q});

   assign d_w       = address_B - address_A;
   assign d_ext_w   = {1'b0, d_w};
   assign len_ext_w = {1'b0, len};
   assign null_w    = (len == '0) || (address_A == address_B);
   assign ovl_w     = (d_ext_w < len_ext_w) || ((DEPTH_C - d_ext_w) < len_ext_w);
   assign desc_w    = (d_w != '0) && (d_ext_w < len_ext_w);

   // Single write port: host owns it while idle, the engine while busy.
   always_comb begin
      mem_we_d   = 1'b0;
      mem_addr_d = address_w;
      mem_data_d = data_w;
      case (state_q)
         S_MOVE: begin
            mem_we_d   = ~reset;
            mem_addr_d = addr_a_w;
            mem_data_d = mem_q[addr_b_w];
         end
         S_STORE: begin
            mem_we_d   = ~reset;
            mem_addr_d = addr_b_w;
            mem_data_d = tmp_q;
         end
         S_COPY: begin
            mem_we_d   = ~reset;
            mem_addr_d = addr_b_w;
            mem_data_d = mem_q[addr_a_w];
         end
         S_LOAD:  mem_we_d = 1'b0;
         default: mem_we_d = we;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we_d) begin
         mem_q[mem_addr_d] <= mem_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_LOAD: begin
               tmp_q   <= mem_q[addr_a_w];
               state_q <= S_MOVE;
            end
            S_MOVE: state_q <= S_STORE;
            S_STORE, S_COPY: begin
               idx_q <= idx_q + ONE_C;
               if (last_w) begin
                  state_q <= S_FIN;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else if (state_q == S_STORE) begin
                  state_q <= S_LOAD;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               if (start) begin
                  a_q    <= address_A;
                  b_q    <= address_B;
                  len_q  <= len;
                  idx_q  <= '0;
                  desc_q <= op & desc_w;
                  if (null_w) begin
                     state_q <= S_FIN;
                     done_q  <= 1'b1;
                  end else if (!op && ovl_w) begin
                     state_q <= S_FIN;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                  end else begin
                     state_q <= op ? S_COPY : S_LOAD;
                     busy_q  <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire
